// File: rtl/ppm16_rx_pkg.sv
// Shared encodings for the 16-PPM receive sequencer and its nibble packer.
package ppm16_rx_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRstDemod = 3'd1,
    StArm      = 3'd2,
    StSearch   = 3'd3,
    StReceive  = 3'd4,
    StDone     = 3'd5
  } state_e;

  // End-of-receive status codes
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_OVERFLOW = 2'd2;
  localparam logic [1:0] ST_ABORT    = 2'd3;

  // Cycles the demodulator is held in reset before each arm
  localparam int unsigned DEMOD_RST_CYCLES = 2;

endpackage

// File: rtl/ppm16_nibble_packer.sv
// Pairs demodulated nibbles into bytes (first nibble high) and holds them in a
// single-entry valid/ready output register. Bytes that find the register full
// are dropped and recorded in a sticky overflow flag.
module ppm16_nibble_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        nib_valid,
  input  logic [3:0]  nib,
  input  logic        byte_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [15:0] byte_count,
  output logic        overflow,
  output logic        phase
);

  logic        phase_q, phase_d;
  logic [3:0]  hi_q, hi_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] count_q, count_d;
  logic        ovf_q, ovf_d;

  // Next-state for phase, high nibble, output register, overflow and count
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (valid_q && byte_ready) begin
      valid_d = 1'b0;
    end
    if (en && nib_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = nib;
      end else if (!valid_q || byte_ready) begin
        // Load may coincide with the accept of the previous byte: no bubble
        valid_d = 1'b1;
        data_d  = {hi_q, nib};
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
    // A pending byte survives a new start; only per-receive state is cleared
    if (clear) begin
      phase_d = 1'b0;
      count_d = 16'd0;
      ovf_d   = 1'b0;
    end
  end

  // Packer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      count_q <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_count = count_q;
  assign overflow   = ovf_q;
  assign phase      = phase_q;

endmodule

// File: rtl/ppm16_rx_ctrl.sv
// Receive sequencer for the 16-PPM demodulator: reset/arm, search with timeout
// and retry, byte packing during receive, and end-of-packet status reporting.
module ppm16_rx_ctrl
  import ppm16_rx_pkg::*;
#(
  parameter int unsigned CHIP_BITS  = 2,
  parameter int unsigned TO_W       = 16,
  parameter int unsigned GAP_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHIP_BITS-1:0] cfg_threshold,
  input  logic [TO_W-1:0]      cfg_search_timeout,
  input  logic [3:0]           cfg_max_retries,
  output logic                 demod_resetn,
  output logic                 demod_rx_start,
  output logic [CHIP_BITS-1:0] demod_corr_threshold,
  input  logic                 demod_packet_detected,
  input  logic                 demod_dout_valid,
  input  logic [3:0]           demod_dout,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  input  logic                 byte_ready,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [15:0]          byte_count,
  output logic                 odd_nibble
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] ToOne = TO_W'(1);
  localparam logic [1:0] RstLast = 2'(DEMOD_RST_CYCLES - 1);

  state_e state_q, state_d;

  logic [TO_W-1:0]      to_q, search_cnt_q;
  logic [3:0]           max_retries_q, retry_q;
  logic [1:0]           rst_cnt_q;
  logic [GapW-1:0]      gap_q;
  logic                 resetn_q, rx_start_q, busy_q, done_q, odd_q;
  logic [1:0]           status_q;
  logic [CHIP_BITS-1:0] thr_q;

  logic       resetn_d, rx_start_d, busy_d, done_d;
  logic       retry_inc;
  logic [1:0] done_status;
  logic       start_acc, search_hit, overflow, phase;

  assign start_acc  = start && (state_q == StIdle);
  assign search_hit = (to_q != '0) && (search_cnt_q == to_q - ToOne);

  // State, registered outputs and end-of-receive status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      resetn_q   <= 1'b0;
      rx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_OK;
      odd_q      <= 1'b0;
      thr_q      <= '0;
    end else begin
      state_q    <= state_d;
      resetn_q   <= resetn_d;
      rx_start_q <= rx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (start_acc) begin
        status_q <= ST_OK;
        odd_q    <= 1'b0;
        thr_q    <= cfg_threshold;
      end else if (state_d == StDone) begin
        status_q <= done_status;
        odd_q    <= phase;
      end
    end
  end

  // Next-state: abort beats timeout, detection and gap expiry
  always_comb begin
    state_d     = state_q;
    retry_inc   = 1'b0;
    done_status = ST_OK;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRstDemod;
      end
      StRstDemod: begin
        if (abort) begin
          state_d     = StDone;
          done_status = ST_ABORT;
        end else if (rst_cnt_q == RstLast) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (abort) begin
          state_d     = StDone;
          done_status = ST_ABORT;
        end else begin
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (abort) begin
          state_d     = StDone;
          done_status = ST_ABORT;
        end else if (demod_packet_detected) begin
          state_d = StReceive;
        end else if (search_hit) begin
          if (retry_q < max_retries_q) begin
            retry_inc = 1'b1;
            state_d   = StRstDemod;
          end else begin
            state_d     = StDone;
            done_status = ST_TIMEOUT;
          end
        end
      end
      StReceive: begin
        if (abort) begin
          state_d     = StDone;
          done_status = ST_ABORT;
        end else if (!demod_dout_valid && gap_q == GapLast) begin
          state_d     = StDone;
          done_status = overflow ? ST_OVERFLOW : ST_OK;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track the state
  always_comb begin
    resetn_d   = (state_d != StRstDemod);
    rx_start_d = (state_d == StArm);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  // Latched config, retry count and per-state cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q          <= '0;
      max_retries_q <= 4'd0;
      retry_q       <= 4'd0;
      search_cnt_q  <= '0;
      rst_cnt_q     <= 2'd0;
      gap_q         <= '0;
    end else begin
      if (start_acc) begin
        to_q          <= cfg_search_timeout;
        max_retries_q <= cfg_max_retries;
        retry_q       <= 4'd0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 4'd1;
      end
      search_cnt_q <= (state_q == StSearch) ? search_cnt_q + ToOne : '0;
      rst_cnt_q    <= (state_q == StRstDemod) ? rst_cnt_q + 2'd1 : 2'd0;
      if (state_q != StReceive || demod_dout_valid) begin
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + GapW'(1);
      end
    end
  end

  ppm16_nibble_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_acc),
    .en         (state_q == StReceive),
    .nib_valid  (demod_dout_valid),
    .nib        (demod_dout),
    .byte_ready (byte_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_count (byte_count),
    .overflow   (overflow),
    .phase      (phase)
  );

  assign demod_resetn         = resetn_q;
  assign demod_rx_start       = rx_start_q;
  assign demod_corr_threshold = thr_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign status               = status_q;
  assign odd_nibble           = odd_q;

endmodule

// File: tb/tb_ppm16_rx_ctrl.sv
// Directed bench for ppm16_rx_ctrl. Inputs change and outputs are sampled 1 ns
// after each rising edge; "cycle k" is the interval after the k-th edge.
module tb_ppm16_rx_ctrl;

  localparam int unsigned G = 16;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  cfg_threshold;
  logic [15:0] cfg_search_timeout;
  logic [3:0]  cfg_max_retries;
  logic        demod_resetn, demod_rx_start;
  logic [1:0]  demod_corr_threshold;
  logic        demod_packet_detected, demod_dout_valid;
  logic [3:0]  demod_dout;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;
  logic        busy, done, odd_nibble;
  logic [1:0]  status;
  logic [15:0] byte_count;

  int errors = 0;
  int checks = 0;
  int arm_cnt, low_cnt;
  logic seen_valid, seen_done;

  always #5 clk = ~clk;

  ppm16_rx_ctrl #(
    .CHIP_BITS  (2),
    .TO_W       (16),
    .GAP_CYCLES (G)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .cfg_threshold         (cfg_threshold),
    .cfg_search_timeout    (cfg_search_timeout),
    .cfg_max_retries       (cfg_max_retries),
    .demod_resetn          (demod_resetn),
    .demod_rx_start        (demod_rx_start),
    .demod_corr_threshold  (demod_corr_threshold),
    .demod_packet_detected (demod_packet_detected),
    .demod_dout_valid      (demod_dout_valid),
    .demod_dout            (demod_dout),
    .byte_valid            (byte_valid),
    .byte_data             (byte_data),
    .byte_ready            (byte_ready),
    .busy                  (busy),
    .done                  (done),
    .status                (status),
    .byte_count            (byte_count),
    .odd_nibble            (odd_nibble)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a receive and detect in the first SEARCH cycle; returns in cycle 5 (RECEIVE)
  task automatic run_to_receive(input logic [1:0] thr, input logic [15:0] to);
    cfg_threshold      = thr;
    cfg_search_timeout = to;
    cfg_max_retries    = 4'd0;
    start              = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    demod_packet_detected = 1'b1;
    tick();
    demod_packet_detected = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_threshold = 2'd0; cfg_search_timeout = 16'd0; cfg_max_retries = 4'd0;
    demod_packet_detected = 1'b0; demod_dout_valid = 1'b0; demod_dout = 4'd0;
    byte_ready = 1'b0;
    tick();
    tick();
    check("rst_resetn", demod_resetn, 0);
    check("rst_rx_start", demod_rx_start, 0);
    check("rst_threshold", demod_corr_threshold, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_count", byte_count, 0);
    reset = 1'b0;
    tick();
    check("idle_resetn", demod_resetn, 1);

    // Nominal: detect 50 cycles after arm, nibbles A,5,3,C
    cfg_threshold = 2'd1; cfg_search_timeout = 16'd1000; cfg_max_retries = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_busy", busy, 1);
    check("nom_resetn_c1", demod_resetn, 0);
    check("nom_threshold", demod_corr_threshold, 1);
    tick();
    check("nom_resetn_c2", demod_resetn, 0);
    check("nom_arm_c2", demod_rx_start, 0);
    tick();
    check("nom_resetn_c3", demod_resetn, 1);
    check("nom_arm_c3", demod_rx_start, 1);
    tick();
    check("nom_arm_c4", demod_rx_start, 0);
    repeat (49) tick();
    demod_packet_detected = 1'b1;
    tick();
    demod_packet_detected = 1'b0;
    byte_ready = 1'b1;
    demod_dout_valid = 1'b1; demod_dout = 4'hA;
    tick();
    demod_dout = 4'h5;
    tick();
    check("nom_b0_valid", byte_valid, 1);
    check("nom_b0_data", byte_data, 8'hA5);
    check("nom_b0_count", byte_count, 1);
    demod_dout = 4'h3;
    tick();
    check("nom_accepted", byte_valid, 0);
    demod_dout = 4'hC;
    tick();
    check("nom_b1_data", byte_data, 8'h3C);
    check("nom_b1_count", byte_count, 2);
    demod_dout_valid = 1'b0;
    repeat (G - 1) tick();
    check("nom_done_early", done, 0);
    tick();
    check("nom_done", done, 1);
    check("nom_status", status, 0);
    check("nom_odd", odd_nibble, 0);
    check("nom_done_busy", busy, 1);
    tick();
    check("nom_done_pulse", done, 0);
    check("nom_idle_busy", busy, 0);

    // Timeout with two retries: DONE lands exactly 70 cycles after start
    cfg_threshold = 2'd2; cfg_search_timeout = 16'd20; cfg_max_retries = 4'd2;
    start = 1'b1;
    arm_cnt = 0; low_cnt = 0; seen_valid = 1'b0; seen_done = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      start = 1'b0;
      arm_cnt += int'(demod_rx_start);
      low_cnt += int'(!demod_resetn);
      if (byte_valid) seen_valid = 1'b1;
      if (k < 70 && done) seen_done = 1'b1;
      if (k == 26) check("to_rearm_c26", demod_rx_start, 1);
    end
    check("to_arm_pulses", arm_cnt, 3);
    check("to_resetn_low", low_cnt, 6);
    check("to_no_byte", seen_valid, 0);
    check("to_no_early_done", seen_done, 0);
    check("to_done", done, 1);
    check("to_status", status, 1);
    tick();

    // Backpressure: 0x12 held, 0x34 dropped; start while busy is ignored
    byte_ready = 1'b0;
    run_to_receive(2'd1, 16'd0);
    demod_dout_valid = 1'b1; demod_dout = 4'h1;
    start = 1'b1; cfg_threshold = 2'd3;
    tick();
    start = 1'b0;
    check("bp_thr_kept", demod_corr_threshold, 1);
    check("bp_busy_start", busy, 1);
    demod_dout = 4'h2;
    tick();
    demod_dout = 4'h3;
    tick();
    check("bp_b0_valid", byte_valid, 1);
    demod_dout = 4'h4;
    tick();
    demod_dout_valid = 1'b0;
    check("bp_held_data", byte_data, 8'h12);
    check("bp_count", byte_count, 1);
    repeat (G) tick();
    check("bp_done", done, 1);
    check("bp_status", status, 2);
    check("bp_data_done", byte_data, 8'h12);
    tick();
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", byte_valid, 1);
    byte_ready = 1'b1;
    tick();
    check("bp_drained", byte_valid, 0);

    // Odd trailer: nibbles 1,2,3
    run_to_receive(2'd1, 16'd0);
    demod_dout_valid = 1'b1; demod_dout = 4'h1;
    tick();
    demod_dout = 4'h2;
    tick();
    demod_dout = 4'h3;
    check("odd_b0_data", byte_data, 8'h12);
    tick();
    demod_dout_valid = 1'b0;
    repeat (G) tick();
    check("odd_done", done, 1);
    check("odd_status", status, 0);
    check("odd_flag", odd_nibble, 1);
    check("odd_count", byte_count, 1);
    tick();

    // Abort in the same cycle as gap expiry
    run_to_receive(2'd1, 16'd0);
    demod_dout_valid = 1'b1; demod_dout = 4'h7;
    tick();
    demod_dout = 4'h8;
    tick();
    demod_dout_valid = 1'b0;
    repeat (G - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_done", done, 1);
    check("ab_status", status, 3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_busy", busy, 0);
    check("ab_idle_done", done, 0);
    check("ab_status_held", status, 3);

    // Reset mid-RECEIVE with a pending byte
    byte_ready = 1'b0;
    run_to_receive(2'd2, 16'd0);
    demod_dout_valid = 1'b1; demod_dout = 4'h9;
    tick();
    demod_dout = 4'h6;
    tick();
    demod_dout_valid = 1'b0;
    check("mr_pending", byte_valid, 1);
    check("mr_pending_data", byte_data, 8'h96);
    reset = 1'b1;
    tick();
    check("mr_valid", byte_valid, 0);
    check("mr_data", byte_data, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_status", status, 0);
    check("mr_count", byte_count, 0);
    check("mr_resetn", demod_resetn, 0);
    check("mr_threshold", demod_corr_threshold, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("mr_no_done", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppm16_rx_ctrl.md
Name: ppm16_rx_ctrl

Overview:
Receive-side sequencer for the 16-PPM demodulator. It resets and arms the demodulator, programs its correlation threshold, and watches for packet detection with a timeout and retry policy. After detection it packs the demodulated nibbles into bytes for a valid/ready consumer, then reports end-of-packet status. It sits between the host/config logic and ppm16_demod.

Parameters:
CHIP_BITS, 2, width of demodulator correlation threshold
TO_W, 16, width of search-timeout counter
GAP_CYCLES, 256, idle cycles after the last dout_valid that mark end of packet (must be >= 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a receive; honoured only in IDLE
abort  in  1  single-cycle abort; honoured in any non-IDLE state
cfg_threshold  in  CHIP_BITS  correlation threshold, latched on accepted start
cfg_search_timeout  in  TO_W  search-window length in cycles; 0 = no timeout; latched on start
cfg_max_retries  in  4  re-arm attempts after timeout; latched on start
demod_resetn  out  1  active-low reset to demodulator
demod_rx_start  out  1  one-cycle arm pulse to demodulator
demod_corr_threshold  out  CHIP_BITS  registered threshold to demodulator
demod_packet_detected  in  1  detection flag from demodulator
demod_dout_valid  in  1  nibble strobe from demodulator
demod_dout  in  4  demodulated nibble
byte_valid  out  1  output byte available
byte_data  out  8  output byte; first nibble received is [7:4]
byte_ready  in  1  consumer accepts byte when byte_valid && byte_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on DONE entry
status  out  2  valid on done: 0 OK, 1 TIMEOUT, 2 OVERFLOW, 3 ABORT
byte_count  out  16  bytes produced this receive; saturates at 0xFFFF
odd_nibble  out  1  trailing unpaired nibble was dropped; valid on done

Behaviour:
- Reset: state IDLE, demod_resetn=0, demod_rx_start=0, demod_corr_threshold=0, byte_valid=0, byte_data=0, busy=0, done=0, status=0, byte_count=0, odd_nibble=0; all counters and flags clear.
- A reset asserted mid-operation abandons the receive immediately. It produces no done pulse and drops any pending byte.
- States: IDLE, RST_DEMOD, ARM, SEARCH, RECEIVE, DONE.
- IDLE: demod_resetn=1. When start=1 in cycle t:
  - latch cfg_*; clear byte_count, odd_nibble, overflow flag and retry count;
  - go to RST_DEMOD.
- RST_DEMOD: lasts 2 cycles with demod_resetn=0 (cycles t+1 and t+2), then ARM.
- ARM: 1 cycle with demod_rx_start=1 (cycle t+3), then SEARCH.
- SEARCH: a cycle counter runs from 0.
  - demod_packet_detected=1 goes to RECEIVE next cycle.
  - Otherwise, when the counter reaches cfg_search_timeout-1 (timeout != 0):
    - if retries < cfg_max_retries: increment retries and go to RST_DEMOD;
    - else go to DONE with status TIMEOUT.
  - If detection and timeout fall in the same cycle, detection wins.
- RECEIVE: each demod_dout_valid toggles the nibble phase.
  - Phase 0: store the high nibble.
  - Phase 1: complete the byte and push it to the output register.
  - The gap counter resets on every demod_dout_valid. When GAP_CYCLES idle cycles have elapsed, go to DONE.
  - dout_valid in the first RECEIVE cycle (the detection-plus-one cycle) is captured.
- Output register (single entry):
  - A completed byte is loaded if byte_valid=0 or byte_ready=1 in the same cycle. A simultaneous accept-and-load is legal and yields no bubble.
  - Otherwise the new byte is dropped and the sticky overflow flag is set.
  - byte_count increments on each load.
  - byte_valid stays high until accepted, including through DONE and IDLE.
  - byte_data is stable while byte_valid && !byte_ready.
- DONE: 1 cycle. done=1, busy=1; status and odd_nibble are held until the next accepted start. Then IDLE.
  - status = OVERFLOW if the overflow flag is set, else OK (RECEIVE path).
  - odd_nibble = nibble phase is 1.
- Abort in RST_DEMOD, ARM, SEARCH or RECEIVE goes to DONE next cycle with status ABORT. Abort wins over timeout, detection and gap expiry.
- Abort in IDLE or DONE is ignored.
- start is ignored while busy. start and abort asserted together in IDLE: start is accepted.
- demod_corr_threshold updates only on an accepted start.

Decomposition:
- Package ppm16_rx_pkg holds:
  - state encoding localparams (3-bit);
  - status codes ST_OK, ST_TIMEOUT, ST_OVERFLOW, ST_ABORT;
  - DEMOD_RST_CYCLES=2.
- Sub-module ppm16_nibble_packer: nibble phase, high-nibble register, single-entry output register, overflow flag and byte_count. The FSM lives in the top.

Test Plan:
- Nominal: threshold=1, timeout=1000; detection 50 cycles after arm, then nibbles A,5,3,C with byte_ready=1 -> bytes 0xA5 then 0x3C, byte_count=2, done with status OK, odd_nibble=0.
- Timeout with retry: timeout=20, max_retries=2, no detection -> three arm pulses, each preceded by 2 cycles of demod_resetn=0; done with TIMEOUT at cycle 3+3*(3+20)-ish (bench checks exact cycle); byte_valid never asserted.
- Backpressure: byte_ready=0 while 2 bytes complete -> first byte held in byte_data, second dropped, byte_count=1; at end, status OVERFLOW.
- Odd trailer: nibbles 1,2,3 then silence -> byte 0x12 emitted; after GAP_CYCLES, done with status OK and odd_nibble=1.
- Abort vs gap: abort in the same cycle as gap expiry -> status ABORT. start during busy -> no effect, cfg changes ignored.
- Reset mid-RECEIVE with byte_valid=1 -> next cycle all outputs at reset values, no done pulse.
